// File: rtl/serial_tx.sv
// serial_tx: framed LSB-first serial transmitter; define SERIAL_TX_PARITY_EN to add an even-parity bit
module serial_tx #(
    parameter int WIDTH = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    output logic             TXD,
    output logic             BUSY
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_AFTER  = S_PARITY;
`else
    localparam logic [2:0] S_AFTER  = S_STOP;
`endif
    logic [2:0]       state, state_n;
    logic [CW-1:0]    cyc, cyc_n;
    logic [BW-1:0]    bitc, bitc_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             last, txd_n;
    assign last = cyc == CW'(CLKS_PER_BIT - 1);
    assign BUSY = ~READY;
    always_comb begin
        state_n = state;
        cyc_n   = last ? '0 : cyc + 1'b1;
        bitc_n  = bitc;
        shreg_n = shreg;
        case (state)
            S_IDLE: begin
                cyc_n = '0;
                if (VALID) begin
                    state_n = S_START;
                    bitc_n  = '0;
                    shreg_n = DATA;
                end
            end
            S_START: state_n = last ? S_DATA : S_START;
            S_DATA: if (last) begin
                if (bitc == BW'(WIDTH - 1)) state_n = S_AFTER;
                else begin
                    bitc_n  = bitc + 1'b1;
                    shreg_n = shreg >> 1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: state_n = last ? S_STOP : S_PARITY;
`endif
            S_STOP: state_n = last ? S_IDLE : S_STOP;
            default: state_n = S_IDLE;
        endcase
    end
`ifdef SERIAL_TX_PARITY_EN
    // parity is taken from the word at handshake since the shift register is consumed
    logic par;
    always_ff @(posedge CLK) begin
        if (RESET) par <= 1'b0;
        else if (state == S_IDLE && VALID) par <= ^DATA;
    end
    assign txd_n = state_n == S_START ? 1'b0 :
                   state_n == S_DATA ? shreg_n[0] :
                   state_n == S_PARITY ? par : 1'b1;
`else
    assign txd_n = state_n == S_START ? 1'b0 :
                   state_n == S_DATA ? shreg_n[0] : 1'b1;
`endif
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            cyc   <= '0;
            bitc  <= '0;
            shreg <= '0;
            TXD   <= 1'b1;
            READY <= 1'b1;
        end else begin
            state <= state_n;
            cyc   <= cyc_n;
            bitc  <= bitc_n;
            shreg <= shreg_n;
            TXD   <= txd_n;
            READY <= state_n == S_IDLE;
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized self-checking bench for serial_tx against a frame-level model
module tb_serial_tx;
    localparam int WIDTH = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = WIDTH + 2 + PAR;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic [WIDTH-1:0] DATA = '0;
    logic VALID = 1'b0;
    logic READY, TXD, BUSY;
    int vectors = 0;
    int errors = 0;

    serial_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RESET(RESET), .DATA(DATA), .VALID(VALID),
        .READY(READY), .TXD(TXD), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [NB-1:0] model(input logic [WIDTH-1:0] d);
        logic [NB-1:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) f[1+i] = d[i];
        if (PAR == 1) f[WIDTH+1] = ^d;
        return f;
    endfunction

    task automatic frame(input logic [WIDTH-1:0] d, input logic keep, input logic [WIDTH-1:0] d2);
        logic [NB-1:0] f;
        int t;
        f = model(d);
        t = 0;
        @(negedge CLK);
        while (READY !== 1'b1 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        vectors++;
        if (READY !== 1'b1) begin
            $display("FAIL ready_wait data=%h READY=%b want 1", d, READY);
            errors++;
        end
        DATA = d;
        VALID = 1'b1;
        @(posedge CLK);
        #1;
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < CPB; c++) begin
                vectors++;
                if ({TXD, BUSY, READY} !== {f[k], 1'b1, 1'b0}) begin
                    $display("FAIL frame data=%h bit=%0d cyc=%0d {TXD,BUSY,READY}=%b want %b",
                             d, k, c, {TXD, BUSY, READY}, {f[k], 2'b10});
                    errors++;
                end
                @(negedge CLK);
                if (k == 0 && c == 0) begin
                    VALID = keep;
                    DATA = d2;
                end
                @(posedge CLK);
                #1;
            end
        end
        vectors++;
        if ({TXD, BUSY, READY} !== 3'b101) begin
            $display("FAIL frame_end data=%h {TXD,BUSY,READY}=%b want 101", d, {TXD, BUSY, READY});
            errors++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        VALID = 1'b1;
        DATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if ({TXD, READY, BUSY} !== 3'b110) begin
            $display("FAIL reset {TXD,READY,BUSY}=%b want 110", {TXD, READY, BUSY});
            errors++;
        end
        @(negedge CLK);
        VALID = 1'b0;
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            vectors++;
            if ({TXD, READY, BUSY} !== 3'b110) begin
                $display("FAIL idle cyc=%0d {TXD,READY,BUSY}=%b want 110", i, {TXD, READY, BUSY});
                errors++;
            end
        end
    endtask

    task automatic test_single();
        frame(8'hA5, 1'b0, 8'h00);
    endtask

    task automatic test_parity();
        frame(8'hA5, 1'b0, 8'hFF);
        frame(8'h07, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        frame(8'h00, 1'b1, 8'hFF);
        frame(8'hFF, 1'b0, 8'h00);
    endtask

    task automatic test_data_stability();
        frame(8'h3C, 1'b0, 8'hC3);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge CLK);
        DATA = 8'h55;
        VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        VALID = 1'b0;
        DATA = 8'h00;
        repeat (4 * CPB + 1) @(posedge CLK);
        #1;
        vectors++;
        if ({TXD, BUSY} !== 2'b01) begin
            $display("FAIL mid_bit3 {TXD,BUSY}=%b want 01", {TXD, BUSY});
            errors++;
        end
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        vectors++;
        if ({TXD, READY, BUSY} !== 3'b110) begin
            $display("FAIL mid_reset {TXD,READY,BUSY}=%b want 110", {TXD, READY, BUSY});
            errors++;
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(posedge CLK);
            #1;
            vectors++;
            if ({TXD, READY} !== 2'b11) begin
                $display("FAIL no_resume cyc=%0d {TXD,READY}=%b want 11", i, {TXD, READY});
                errors++;
            end
        end
        frame(8'h81, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] d, d2;
            logic keep;
            d = WIDTH'($urandom);
            d2 = WIDTH'($urandom);
            keep = 1'($urandom_range(0, 1));
            frame(d, keep, d2);
            if (keep) begin
                @(negedge CLK);
                VALID = 1'b0;
                repeat (NB * CPB + 4) @(posedge CLK);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_data_stability();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
